wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage, directly downstream of the memory stage.
- Captures each one-cycle mem_wb pulse with its 128-bit mem_result and destination info into a 2-entry FIFO.
- Drains the FIFO into the 64-bit architectural register file at one write per cycle.
- Dual-destination results (e.g. RDX:RAX) are split into two sequential writes. Asserts wb_blocked back to the memory stage when it cannot accept.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2)
- NREG, 16, architectural GPRs; index width = log2(NREG)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_wb  in  1  one-cycle pulse: result valid this cycle
- mem_result  in  128  result; [63:0] to dst1, [127:64] to dst2
- dst1_en  in  1  write dst1
- dst1  in  4  dst1 register index
- dst2_en  in  1  write dst2
- dst2  in  4  dst2 register index
- wb_blocked  out  1  FIFO full; upstream must not pulse mem_wb
- rf_wren  out  1  register-file write strobe
- rf_waddr  out  4  write index
- rf_wdata  out  64  write data
- retired  out  64  count of retired entries
- overflow  out  1  sticky: pulse arrived while full
- fwd_valid  out  1  forwarding valid (WB_FWD_EN)
- fwd_idx  out  4  forwarding index
- fwd_data  out  64  forwarding data

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: all outputs 0, FIFO empty (count=0, rd/wr pointers 0), phase=WB_LO.
- Reset mid-operation flushes all entries, including any half-written dual-destination entry. No further rf_wren until a new push.
- Push: on posedge with mem_wb=1 and count<DEPTH, store {mem_result, dst1_en, dst1, dst2_en, dst2} at wr_ptr. wr_ptr wraps modulo DEPTH.
- Push while full (count==DEPTH): entry dropped, overflow<=1. overflow is sticky until reset.
- wb_blocked is combinational: count==DEPTH.
- Drain state machine acts on the FIFO head, WB_LO/WB_HI:
  - WB_LO, FIFO non-empty:
    - dst1_en: register rf_wren=1, rf_waddr=dst1, rf_wdata=result[63:0]. If dst2_en, go to WB_HI and keep the head; else pop.
    - !dst1_en && dst2_en: write dst2 with result[127:64], then pop.
    - Neither enabled: rf_wren=0, pop (consumes one cycle).
  - WB_HI: write dst2 with result[127:64], pop, return to WB_LO.
  - Empty: rf_wren<=0.
- Latency: entry pushed at edge N produces its first rf write registered at edge N+1 when the FIFO was empty and idle. rf outputs are held one cycle only.
- Simultaneous push and pop: both occur and count is unchanged. A push into a full FIFO is still dropped, even if a pop happens in the same cycle.
- Pop: rd_ptr wraps; retired<=retired+1 (wraps at 2^64).
- Same-index dual write (dst1==dst2, both enabled): two writes in order; the hi value lands last.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: fwd_valid/fwd_idx/fwd_data combinationally mirror the write the state machine will register at the next edge. This gives decode/ALU a one-cycle-early bypass.
- Undefined: fwd_* tied to 0; no added logic.

Test Plan:
- Single push: mem_wb pulse, dst1_en=1, dst1=3, result[63:0]=0xDEAD -> next cycle rf_wren=1, rf_waddr=3, rf_wdata=0xDEAD; retired=1.
- Dual dest: dst1=0 (RAX), dst2=2 (RDX), result=0x11..22_33..44 -> two consecutive writes: (0, lo), then (2, hi); retired increments once, after the second.
- Back-to-back pulses: 3 pulses on consecutive cycles, all dual-dest -> wb_blocked rises when count=2. The third pulse is dropped and overflow=1; the first two entries drain correctly over 4 cycles.
- No-dest entry: dst1_en=dst2_en=0 -> no rf_wren, retired increments, FIFO empties.
- Reset during WB_HI: assert reset for 1 cycle -> hi write never occurs; all outputs 0; overflow cleared.
- WB_FWD_EN on: single push dst1=5, data 0x42 -> fwd_valid=1, fwd_idx=5, fwd_data=0x42 in the cycle before rf_wren. With the macro off, fwd_* stay 0.

Source files
------------

// File: rtl/wb_if.sv
// Memory-to-writeback result bus.
// The memory stage drives master; wb_stage is slave.
interface wb_if #(
  parameter int IW = 4
);
  logic          mem_wb;
  logic [127:0]  mem_result;
  logic          dst1_en;
  logic [IW-1:0] dst1;
  logic          dst2_en;
  logic [IW-1:0] dst2;
  logic          wb_blocked;

  modport master (
    output mem_wb, mem_result,
    output dst1_en, dst1,
    output dst2_en, dst2,
    input  wb_blocked
  );

  modport slave (
    input  mem_wb, mem_result,
    input  dst1_en, dst1,
    input  dst2_en, dst2,
    output wb_blocked
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: result FIFO draining to the GPR file.
// Optional bypass port enabled by macro WB_FWD_EN.
module wb_stage #(
  parameter int DEPTH = 2,
  parameter int NREG  = 16,
  localparam int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  wb_if.slave           wb,
  output logic          rf_wren,
  output logic [IW-1:0] rf_waddr,
  output logic [63:0]   rf_wdata,
  output logic [63:0]   retired,
  output logic          overflow,
  output logic          fwd_valid,
  output logic [IW-1:0] fwd_idx,
  output logic [63:0]   fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] WB_LO = 1'b0;
  localparam logic [0:0] WB_HI = 1'b1;

  typedef struct packed {
    logic [127:0]  res;
    logic          d1en;
    logic [IW-1:0] d1;
    logic          d2en;
    logic [IW-1:0] d2;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [0:0]    phase;
  logic [0:0]    nx_phase;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          nx_wren;
  logic [IW-1:0] nx_waddr;
  logic [63:0]   nx_wdata;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = wb.mem_wb && !full;
  assign head  = mem[rd_ptr];

  assign wb.wb_blocked = full;

  always_comb begin
    nx_wren  = 1'b0;
    nx_waddr = '0;
    nx_wdata = '0;
    nx_phase = phase;
    pop      = 1'b0;
    if (!empty) begin
      if (phase == WB_HI) begin
        nx_wren  = 1'b1;
        nx_waddr = head.d2;
        nx_wdata = head.res[127:64];
        nx_phase = WB_LO;
        pop      = 1'b1;
      end else begin
        unique case (1'b1)
          head.d1en: begin
            nx_wren  = 1'b1;
            nx_waddr = head.d1;
            nx_wdata = head.res[63:0];
            if (head.d2en) nx_phase = WB_HI;
            else           pop      = 1'b1;
          end
          !head.d1en && head.d2en: begin
            nx_wren  = 1'b1;
            nx_waddr = head.d2;
            nx_wdata = head.res[127:64];
            pop      = 1'b1;
          end
          !head.d1en && !head.d2en: begin
            pop = 1'b1;
          end
        endcase
      end
    end
  end

  // Entry storage needs no reset: it is only read when count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{
        res:  wb.mem_result,
        d1en: wb.dst1_en,
        d1:   wb.dst1,
        d2en: wb.dst2_en,
        d2:   wb.dst2
      };
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      phase    <= WB_LO;
      rf_wren  <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      retired  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        retired <= retired + 64'd1;
      end
      if (wb.mem_wb && full) overflow <= 1'b1;
      count    <= count + CW'(push) - CW'(pop);
      phase    <= nx_phase;
      rf_wren  <= nx_wren;
      rf_waddr <= nx_waddr;
      rf_wdata <= nx_wdata;
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = nx_wren && !reset;
  assign fwd_idx   = reset ? '0 : nx_waddr;
  assign fwd_data  = reset ? '0 : nx_wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_idx   = '0;
  assign fwd_data  = '0;
`endif

endmodule
